// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of one shared write FIFO.
// A granted producer owns the FIFO for up to MAX_BURST accepted beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [DATA_W-1:0] slice [NUM_REQ];
  logic [GID_W-1:0]  pick_id;
  logic [GID_W-1:0]  next_ptr;
  logic              pick_vld;
  logic              in_burst;
  logic              gnt_valid;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Scan from the highest offset down so the smallest offset wins.
  always_comb begin : arb_scan
    int unsigned idx;
    pick_id  = rr_ptr_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[GID_W'(idx)]) begin
        pick_id  = GID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign in_burst  = (state_q == BURST);
  assign gnt_valid = req_valid[grant_id_q];
  assign next_ptr  = (grant_id_q == LAST_ID) ? '0
                                             : grant_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  assign wr_en    = gnt_valid && req_ready[grant_id_q];
  assign data_in  = in_burst ? slice[grant_id_q] : '0;
  assign grant_id = grant_id_q;
  assign busy     = in_burst;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (wr_en) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        // A dropped valid ends the burst even when the FIFO is full.
        if (!gnt_valid ||
            (wr_en && burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              wr_en;
  logic [DW-1:0]     data_in;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the FIFO, beats done, next scan start.
  bit m_active;
  int m_who;
  int m_done;
  int m_ptr;

  int seq [N];
  int sb_seq [N];
  int waits [N];
  int last_w;
  bit prev_busy;
  logic [N-1:0] prev_valid;
  int glog [$];
  logic [DW-1:0] wlog [$];

  function automatic logic [DW-1:0] base_of(input int i);
    return DW'(32'h00A0 + 32'h1000 * i);
  endfunction

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Starts just after a rising edge, ends just after the next one.
  task automatic run_cycle(input logic [N-1:0] v, input logic f);
    logic [N-1:0]  exp_rdy;
    logic          exp_wr;
    logic [DW-1:0] exp_dat;
    int            w;
    bit            rep;
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < N; i++)
      req_data[i*DW +: DW] = base_of(i) + DW'(seq[i]);
    @(negedge clk);
    exp_rdy = (m_active && !f) ? (N'(1) << m_who) : '0;
    exp_wr  = m_active && v[m_who] && !f;
    exp_dat = m_active ? base_of(m_who) + DW'(seq[m_who]) : '0;
    check("busy", 32'(busy), 32'(m_active));
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("wr_en", 32'(wr_en), 32'(exp_wr));
    check("data_in", 32'(data_in), 32'(exp_dat));
    check("grant_id", 32'(grant_id), 32'(m_who));
    if (wr_en === 1'b1) begin
      w = int'(grant_id);
      check("write_while_full", 32'(fifo_full), 0);
      check("in_order", 32'(data_in),
            32'(base_of(w) + DW'(sb_seq[w])));
      sb_seq[w]++;
      wlog.push_back(data_in);
    end
    if (busy === 1'b1 && !prev_busy) begin
      w = int'(grant_id);
      rep = 0;
      glog.push_back(w);
      for (int j = 0; j < N; j++) begin
        if (j != w) begin
          if (prev_valid[j]) begin
            waits[j]++;
            if (w == last_w) rep = 1;
          end else begin
            waits[j] = 0;
          end
          check("starve", 32'(waits[j] > 3), 0);
        end
      end
      waits[w] = 0;
      check("rr_repeat", 32'(rep), 0);
      last_w = w;
    end
    prev_busy  = (busy === 1'b1);
    prev_valid = v;
    if (!m_active) begin
      w = pick(m_ptr, v);
      if (w >= 0) begin
        m_active = 1;
        m_who    = w;
        m_done   = 0;
      end
    end else if (!v[m_who]) begin
      m_active = 0;
      m_ptr    = (m_who + 1) % N;
    end else if (!f) begin
      seq[m_who]++;
      m_done++;
      if (m_done == MB) begin
        m_active = 0;
        m_ptr    = (m_who + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst_n     = 1'b0;
    req_valid = v;
    fifo_full = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_data", 32'(data_in), 0);
    check("rst_grant", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    check("rst_hold_busy", 32'(busy), 0);
    check("rst_hold_wr", 32'(wr_en), 0);
    rst_n    = 1'b1;
    m_active = 0;
    m_who    = 0;
    m_ptr    = 0;
    m_done   = 0;
    last_w   = -1;
    prev_busy = 0;
    for (int j = 0; j < N; j++) waits[j] = 0;
    glog.delete();
    wlog.delete();
  endtask

  int exp33 [5] = '{0, 1, 2, 3, 0};
  int exp35 [3] = '{1, 3, 1};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    prev_valid = '0;
    for (int j = 0; j < N; j++) begin
      seq[j]    = 0;
      sb_seq[j] = 0;
    end
    @(posedge clk);
    #1;

    // Single requester, two back-to-back bursts.
    do_reset('0);
    for (int c = 0; c < 10; c++) run_cycle(4'b0001, 1'b0);
    check("r32_nwr", 32'(wlog.size()), 8);
    for (int i = 0; i < 8; i++)
      check("r32_data", 32'(wlog[i]), 32'(16'hA0 + i));
    check("r32_ngrant", 32'(glog.size()), 2);
    check("r32_g0", 32'(glog[0]), 0);
    check("r32_g1", 32'(glog[1]), 0);

    // Everyone requesting: strict rotation.
    do_reset('0);
    for (int c = 0; c < 25; c++) run_cycle(4'b1111, 1'b0);
    check("r33_ngrant", 32'(glog.size()), 5);
    for (int i = 0; i < 5; i++)
      check("r33_order", 32'(glog[i]), 32'(exp33[i]));
    check("r33_nwr", 32'(wlog.size()), 20);

    // FIFO full for three cycles after beat 2.
    do_reset('0);
    for (int c = 0; c < 3; c++) run_cycle(4'b0100, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(4'b0100, 1'b1);
    check("r34_stalled", 32'(wlog.size()), 2);
    for (int c = 0; c < 3; c++) run_cycle(4'b0100, 1'b0);
    check("r34_nwr", 32'(wlog.size()), 4);
    check("r34_ngrant", 32'(glog.size()), 1);
    check("r34_g", 32'(glog[0]), 2);

    // Producer 1 drops valid after two beats.
    do_reset('0);
    for (int c = 0; c < 3; c++) run_cycle(4'b1010, 1'b0);
    run_cycle(4'b1000, 1'b0);
    for (int c = 0; c < 7; c++) run_cycle(4'b1010, 1'b0);
    check("r35_ngrant", 32'(glog.size()), 3);
    for (int i = 0; i < 3; i++)
      check("r35_order", 32'(glog[i]), 32'(exp35[i]));
    check("r35_nwr", 32'(wlog.size()), 7);

    // Reset in the middle of producer 3's burst.
    do_reset('0);
    for (int c = 0; c < 3; c++) run_cycle(4'b1000, 1'b0);
    check("r36_pre_nwr", 32'(wlog.size()), 2);
    check("r36_pre_wr", 32'(wr_en), 1);
    do_reset(4'b1111);
    for (int c = 0; c < 2; c++) run_cycle(4'b1111, 1'b0);
    check("r36_ngrant", 32'(glog.size()), 1);
    check("r36_first", 32'(glog[0]), 0);

    // Random traffic.
    do_reset('0);
    for (int c = 0; c < 1000; c++) begin
      logic [N-1:0] v;
      logic         f;
      for (int i = 0; i < N; i++)
        v[i] = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      run_cycle(v, f);
    end
    for (int i = 0; i < N; i++)
      check("rand_beats", 32'(sb_seq[i]), 32'(seq[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
